data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the CPU's data-memory port and the backing memory. It consumes the CPU's `dcache_addr/dcache_we/dcache_re/dcache_din`, returns `dcache_dout`, and drives the CPU-wide `stall`. Misses refill a 4-word line over a ready/valid memory request channel with a beat-based response channel. Every store is forwarded to memory as a single masked word write.

---
 rtl/data_cache_if.sv | 32 +++
 rtl/data_cache.sv | 159 +++++++++++++++
 tb/tb_data_cache.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// CPU data port plus memory request/response channel for the data cache.
// The slave modport is the cache side; master is the CPU/memory side.
interface data_cache_if;
  logic [31:0] dcache_addr;
  logic [3:0]  dcache_we;
  logic        dcache_re;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rnw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport slave (
    input  dcache_addr, dcache_we, dcache_re, dcache_din,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output dcache_dout, stall,
    output mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_data, mem_req_mask
  );

  modport master (
    output dcache_addr, dcache_we, dcache_re, dcache_din,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  dcache_dout, stall,
    input  mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_data, mem_req_mask
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Misses refill over a ready/valid request channel; every store goes to memory as one word.
module data_cache #(
  parameter int unsigned INDEX_BITS = 6
) (
  input logic         clk,
  input logic         rst,
  data_cache_if.slave bus
);
  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 28 - INDEX_BITS;

  typedef enum logic [2:0] {
    StIdle, StRefillReq, StRefillData, StWriteReq, StDone
  } state_e;

  state_e              r_state;
  logic                r_pend_active;
  logic [31:2]         r_pend_addr;
  logic [3:0]          r_pend_we;
  logic [31:0]         r_pend_din;
  logic [1:0]          r_beat;
  logic [31:0]         r_refill_word;
  logic [Lines-1:0]    r_valid;
  logic [TagBits-1:0]  r_tag_ram [Lines];
  logic [31:0]         r_data_ram [4*Lines];
  logic [31:0]         r_rdata;
  logic                r_req_valid;
  logic                r_req_rnw;
  logic [31:0]         r_req_addr;
  logic [31:0]         r_req_data;
  logic [3:0]          r_req_mask;

  logic [INDEX_BITS-1:0] w_index;
  logic [TagBits-1:0]    w_tag;
  logic [INDEX_BITS+1:0] w_pend_word;
  logic [INDEX_BITS+1:0] w_rd_word;
  logic                  w_is_write;
  logic                  w_hit;
  logic                  w_stall;
  logic                  w_store_hit;
  logic                  w_beat_we;
  logic                  w_fill_done;

  assign w_index     = r_pend_addr[INDEX_BITS+3:4];
  assign w_tag       = r_pend_addr[31:INDEX_BITS+4];
  assign w_pend_word = r_pend_addr[INDEX_BITS+3:2];
  assign w_is_write  = |r_pend_we;
  assign w_hit       = r_valid[w_index] && (r_tag_ram[w_index] == w_tag);
  // While stalled the RAM keeps reading the pending word so the output stays coherent.
  assign w_rd_word   = w_stall ? w_pend_word : bus.dcache_addr[INDEX_BITS+3:2];
  assign w_store_hit = (r_state == StIdle) && r_pend_active && w_is_write && w_hit;
  assign w_beat_we   = (r_state == StRefillData) && bus.mem_resp_valid;
  assign w_fill_done = w_beat_we && (r_beat == 2'd3);

  always_comb begin
    w_stall = 1'b1;
    case (r_state)
      StIdle:  w_stall = r_pend_active && (w_is_write || !w_hit);
      StDone:  w_stall = 1'b0;
      default: w_stall = 1'b1;
    endcase
  end

  always_comb begin
    bus.dcache_dout = '0;
    if ((r_state == StIdle) && r_pend_active && !w_is_write && w_hit) begin
      bus.dcache_dout = r_rdata;
    end else if ((r_state == StDone) && !w_is_write) begin
      bus.dcache_dout = r_refill_word;
    end
  end

  assign bus.stall         = w_stall;
  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_rnw   = r_req_rnw;
  assign bus.mem_req_addr  = r_req_addr;
  assign bus.mem_req_data  = r_req_data;
  assign bus.mem_req_mask  = r_req_mask;

  // Storage arrays carry no reset; only the valid bits do.
  always_ff @(posedge clk) begin
    r_rdata <= r_data_ram[w_rd_word];
    if (w_store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_pend_we[b]) r_data_ram[w_pend_word][8*b +: 8] <= r_pend_din[8*b +: 8];
      end
    end
    if (w_beat_we)   r_data_ram[{w_index, r_beat}] <= bus.mem_resp_data;
    if (w_fill_done) r_tag_ram[w_index] <= w_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_pend_active <= 1'b0;
      r_pend_addr   <= '0;
      r_pend_we     <= '0;
      r_pend_din    <= '0;
      r_beat        <= '0;
      r_refill_word <= '0;
      r_valid       <= '0;
      r_req_valid   <= 1'b0;
      r_req_rnw     <= 1'b0;
      r_req_addr    <= '0;
      r_req_data    <= '0;
      r_req_mask    <= '0;
    end else begin
      if (!w_stall) begin
        r_pend_active <= bus.dcache_re | (|bus.dcache_we);
        r_pend_addr   <= bus.dcache_addr[31:2];
        r_pend_we     <= bus.dcache_we;
        r_pend_din    <= bus.dcache_din;
      end
      case (r_state)
        StIdle: begin
          if (r_pend_active && w_is_write) begin
            r_state     <= StWriteReq;
            r_req_valid <= 1'b1;
            r_req_rnw   <= 1'b0;
            r_req_addr  <= {r_pend_addr, 2'b00};
            r_req_data  <= r_pend_din;
            r_req_mask  <= r_pend_we;
          end else if (r_pend_active && !w_hit) begin
            r_state     <= StRefillReq;
            r_req_valid <= 1'b1;
            r_req_rnw   <= 1'b1;
            r_req_addr  <= {r_pend_addr[31:4], 4'h0};
          end
        end
        StRefillReq: begin
          if (bus.mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_beat      <= 2'd0;
            r_state     <= StRefillData;
          end
        end
        StRefillData: begin
          if (bus.mem_resp_valid) begin
            if (r_beat == w_pend_word[1:0]) r_refill_word <= bus.mem_resp_data;
            r_beat <= r_beat + 2'd1;
            if (r_beat == 2'd3) begin
              r_valid[w_index] <= 1'b1;
              r_state          <= StDone;
            end
          end
        end
        StWriteReq: begin
          if (bus.mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Randomized and directed bench for data_cache; the reference keeps backing memory as a
// word map plus per-index valid/tag, since write-through keeps cached lines equal to memory.
module tb_data_cache;
  logic clk;
  logic rst;

  data_cache_if bus ();

  data_cache #(.INDEX_BITS(6)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp;
  int          n_bad;
  logic [31:0] mem_m [logic [31:0]];
  logic        m_valid [64];
  logic [21:0] m_tag [64];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    chk({tag, "_dout"}, bus.dcache_dout, 32'd0);
    chk({tag, "_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
    chk({tag, "_req_rnw"}, 32'(bus.mem_req_rnw), 32'd0);
    chk({tag, "_req_addr"}, bus.mem_req_addr, 32'd0);
    chk({tag, "_req_data"}, bus.mem_req_data, 32'd0);
    chk({tag, "_req_mask"}, 32'(bus.mem_req_mask), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    bus.dcache_we = 4'h0;
    bus.dcache_re = 1'b0;
    repeat (n) begin
      @(negedge clk);
      bus.mem_req_ready  = 1'($urandom);
      bus.mem_resp_valid = 1'($urandom);
      bus.mem_resp_data  = $urandom;
      chk("idle_stall", 32'(bus.stall), 32'd0);
      chk("idle_req_valid", 32'(bus.mem_req_valid), 32'd0);
    end
  endtask

  // One CPU access with the bench acting as memory; abort_beat >= 0 asserts reset mid-refill.
  task automatic do_access(input logic [31:0] addr, input logic [3:0] we, input logic re,
                           input logic [31:0] din, input int bp, input int gap_pct,
                           input int abort_beat);
    logic        is_wr, hit, accepted, in_data, done;
    int          idx, stalls, extra, beats, gaps, bp_left, cyc, exp_stalls;
    logic [31:0] waddr, laddr, wd;
    is_wr    = (we != 4'h0);
    idx      = int'(addr[9:4]);
    waddr    = {addr[31:2], 2'b00};
    laddr    = {addr[31:4], 4'h0};
    hit      = m_valid[idx] && (m_tag[idx] == addr[31:10]);
    stalls   = 0;
    extra    = 0;
    beats    = 0;
    gaps     = 0;
    bp_left  = bp;
    cyc      = 0;
    accepted = 1'b0;
    in_data  = 1'b0;
    done     = 1'b0;
    bus.dcache_addr = addr;
    bus.dcache_we   = we;
    bus.dcache_re   = re;
    bus.dcache_din  = din;
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (bus.stall !== 1'b1) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (in_data && beats < 4) begin
          if (beats == abort_beat) begin
            rst           = 1'b1;
            bus.dcache_we = 4'h0;
            bus.dcache_re = 1'b0;
            #1;
            check_reset_outputs("mid_reset");
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            return;
          end
          if (gaps < 6 && $urandom_range(99) < gap_pct) begin
            gaps++;
          end else begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_rd(laddr + 32'(4 * beats));
            beats++;
          end
        end else if ($urandom_range(3) == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = $urandom;
        end
        if (bus.mem_req_valid === 1'b1) begin
          if (accepted) begin
            extra++;
          end else begin
            chk("req_rnw", 32'(bus.mem_req_rnw), 32'(!is_wr));
            chk("req_addr", bus.mem_req_addr, is_wr ? waddr : laddr);
            if (is_wr) begin
              chk("req_data", bus.mem_req_data, din);
              chk("req_mask", 32'(bus.mem_req_mask), 32'(we));
            end
            if (bp_left > 0) begin
              bp_left--;
            end else begin
              bus.mem_req_ready = 1'b1;
              accepted          = 1'b1;
              if (is_wr) begin
                wd = mem_rd(waddr);
                for (int b = 0; b < 4; b++) if (we[b]) wd[8*b +: 8] = din[8*b +: 8];
                mem_m[waddr] = wd;
              end else begin
                in_data = 1'b1;
              end
            end
          end
        end
      end
    end
    chk("done_in_budget", 32'(done), 32'd1);
    if (is_wr)    exp_stalls = bp + 2;
    else if (hit) exp_stalls = 0;
    else          exp_stalls = bp + 6 + gaps;
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("req_count", 32'(accepted), (hit && !is_wr) ? 32'd0 : 32'd1);
    chk("extra_req", 32'(extra), 32'd0);
    chk("req_valid_at_end", 32'(bus.mem_req_valid), 32'd0);
    if (!is_wr) chk("dout", bus.dcache_dout, mem_rd(waddr));
    if (!is_wr && !hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = addr[31:10];
    end
    bus.dcache_we = 4'h0;
    bus.dcache_re = 1'b0;
  endtask

  initial begin
    logic [21:0] tag_pool [4];
    logic [31:0] ra;
    logic [3:0]  rwe;
    n_cmp = 0;
    n_bad = 0;
    tag_pool[0] = 22'd0;
    tag_pool[1] = 22'd1;
    tag_pool[2] = 22'd3;
    tag_pool[3] = 22'd64;
    rst                = 1'b1;
    bus.dcache_addr    = '0;
    bus.dcache_we      = '0;
    bus.dcache_re      = 1'b0;
    bus.dcache_din     = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    mem_m[32'h100] = 32'hA0;
    mem_m[32'h104] = 32'hA1;
    mem_m[32'h108] = 32'hA2;
    mem_m[32'h10C] = 32'hA3;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Cold miss, then a hit on the same line.
    do_access(32'h100, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    do_access(32'h10C, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    // Write hit merges one byte; read back.
    do_access(32'h105, 4'b0010, 1'b0, 32'h0000BB00, 0, 0, -1);
    do_access(32'h104, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    chk("merged_word", mem_rd(32'h104), 32'h0000BBA1);
    // Write miss does not allocate.
    do_access(32'h2000, 4'hF, 1'b1, 32'h12345678, 0, 0, -1);
    do_access(32'h2000, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    // Conflict eviction on index 0x10.
    do_access(32'h500, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    do_access(32'h100, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    // Back-pressure on the refill request.
    do_access(32'h500, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    do_access(32'h100, 4'h0, 1'b1, 32'h0, 5, 0, -1);
    // Reset after beat 1, then the line must miss again.
    do_access(32'h500, 4'h0, 1'b1, 32'h0, 0, 0, 2);
    do_access(32'h100, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    // Back-to-back hits.
    do_access(32'h104, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    do_access(32'h108, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    do_access(32'h10C, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    do_access(32'h100, 4'h0, 1'b1, 32'h0, 0, 0, -1);
    idle_cycles(3);

    for (int k = 0; k < 200; k++) begin
      ra = {tag_pool[$urandom_range(3)], 6'($urandom_range(3)), 4'($urandom)};
      if ($urandom_range(9) < 4) begin
        rwe = 4'($urandom_range(15, 1));
        do_access(ra, rwe, 1'($urandom), $urandom, $urandom_range(2), 25, -1);
      end else begin
        do_access(ra, 4'h0, 1'b1, 32'h0, $urandom_range(2), 25, -1);
      end
      if ($urandom_range(7) == 0) idle_cycles(1 + $urandom_range(2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
